// File: rtl/bigint_pkg.sv
// Shared constants and types for the big-integer arithmetic unit
// (sequential 256x256 multiplier and 512/256 restoring divider).
package bigint_pkg;

    // Divider widths: dividend/quotient, divisor/remainder, step counter.
    localparam int N_W   = 512;
    localparam int D_W   = 256;
    localparam int CNT_W = $clog2(N_W);

    // Limb width of the sequential multiplier datapath.
    localparam int LIMB_W = 64;

    // Divider control states.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ITER      = 2'd1,
        DONE_ZERO = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the
// partial remainder, subtract the divisor when it fits, emit the quotient bit.
module div_step
    import bigint_pkg::*;
(
    input  logic [D_W-1:0] rem,
    input  logic           msb,
    input  logic [D_W-1:0] d,
    output logic [D_W-1:0] rem_next,
    output logic           qbit
);

    // The shifted value needs D_W+1 bits for the compare only; since rem < d
    // on entry, t - d < d, so the result always fits back into D_W bits.
    logic [D_W:0] w_t;

    // Compare-and-conditionally-subtract.
    always_comb begin
        // NOTE: every output gets a default before any conditional update, so
        // no path leaves a value unassigned and no latch is inferred.
        w_t      = {rem, msb};
        qbit     = (w_t >= {1'b0, d});
        rem_next = w_t[D_W-1:0];
        if (qbit) begin
            rem_next = D_W'(w_t - {1'b0, d});
        end
    end

endmodule

// File: rtl/div512_by256_seq.sv
// Sequential restoring divider: 512-bit dividend / 256-bit divisor,
// one quotient bit per clock, start/busy/done handshake.
module div512_by256_seq
    import bigint_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N_W-1:0] N,
    input  logic [D_W-1:0] D,
    output logic           busy,
    output logic           done,
    output logic [N_W-1:0] Q,
    output logic [D_W-1:0] R,
    output logic           dz
);

    div_state_t       r_state;
    logic [N_W-1:0]   r_nq;     // dividend shifting out, quotient shifting in
    logic [D_W-1:0]   r_dreg;
    logic [D_W-1:0]   r_rem;    // extra compare bit lives inside div_step
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_dz;
    logic [N_W-1:0]   r_q;
    logic [D_W-1:0]   r_r;

    logic [D_W-1:0]   w_rem_next;
    logic             w_qbit;
    logic [N_W-1:0]   w_nq_next;

    div_step u_step (
        .rem      (r_rem),
        .msb      (r_nq[N_W-1]),
        .d        (r_dreg),
        .rem_next (w_rem_next),
        .qbit     (w_qbit)
    );

    assign w_nq_next = {r_nq[N_W-2:0], w_qbit};

    // Control FSM, iteration datapath and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_nq    <= '0;
            r_dreg  <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dz    <= 1'b0;
            r_q     <= '0;
            r_r     <= '0;
        end else begin
            // NOTE: state uses non-blocking assignments so every register in
            // this block sees the pre-edge values of the others.
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_nq   <= N;
                        r_dreg <= D;
                        r_rem  <= '0;
                        r_cnt  <= '0;
                        r_busy <= 1'b1;
                        r_state <= (D == '0) ? DONE_ZERO : ITER;
                    end
                end
                ITER: begin
                    r_rem <= w_rem_next;
                    r_nq  <= w_nq_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(N_W - 1)) begin
                        r_q     <= w_nq_next;
                        r_r     <= w_rem_next;
                        r_dz    <= 1'b0;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                DONE_ZERO: begin
                    r_q     <= '1;
                    r_r     <= r_nq[D_W-1:0];
                    r_dz    <= 1'b1;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign Q    = r_q;
    assign R    = r_r;
    assign dz   = r_dz;

endmodule
